// File: rtl/zero_count_stream.sv
// -----------------------------------------------------------------------------
// zero_count_stream
//
// Purpose:
//    Accumulates the number of 0 bits over a frame of WIDTH-bit words received
//    on a valid/ready stream. When the last word of a frame is accepted, the
//    block presents the following on a held valid/ready output:
//       - the (saturating) total
//       - an even-count flag
//       - a divisible-by-MOD flag
//       - a saturation flag
//
// Parameters:
//    Input word width in bits is WIDTH (>=1).
//    The divisor for the divisibility flag is MOD (>=2).
//    The accumulated count is CNT_W bits wide and saturates at 2^CNT_W-1.
//
// Ports:
//    clk        clock, rising edge
//    rst        asynchronous active-high reset
//    in_valid   input word valid
//    in_ready   block can accept a word (high while accumulating)
//    in_data    input word
//    in_last    word is the last of its frame
//    out_valid  frame result valid (held until out_ready)
//    out_ready  consumer accepts result
//    out_count  zeros in frame, saturating
//    out_even   true zero count is even
//    out_mod    true zero count is divisible by the divisor
//    out_ovf    count saturated during the frame
//    sel_ones   (only with ZERO_COUNT_ONES_SEL_EN) count 1 bits instead of 0
//               bits; sampled on the first word of a frame and held for it
//
// Optional feature macro: ZERO_COUNT_ONES_SEL_EN
// -----------------------------------------------------------------------------
module zero_count_stream #(
   parameter int WIDTH = 16,
   parameter int MOD   = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_even,
   output logic             out_mod,
   output logic             out_ovf
`ifdef ZERO_COUNT_ONES_SEL_EN
   ,
   input  logic             sel_ones
`endif
);

   localparam int ZW = $clog2(WIDTH + 1);
   // The sum is one bit wider than the larger operand, so overflow past the
   // saturation point is always visible in the sum.
   localparam int SW = ((CNT_W > ZW) ? CNT_W : ZW) + 1;
   localparam int RW = $clog2(MOD);
   localparam logic [SW-1:0] CNT_MAX = (SW'(1) << CNT_W) - SW'(1);
   localparam logic [31:0]   MOD_U   = MOD;

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             xfer;
   logic             sel_eff;
   logic [WIDTH-1:0] cnt_bits;
   logic [ZW-1:0]    z;
   logic [SW-1:0]    sum;
   logic             sat;
   logic [31:0]      res_sum;

   logic [CNT_W-1:0] acc_q, acc_d;
   logic             par_q, par_d;
   logic [RW-1:0]    res_q, res_d;
   logic             ovf_q, ovf_d;

   logic [CNT_W-1:0] out_count_q;
   logic             out_even_q, out_mod_q, out_ovf_q;

   assign xfer = in_valid && in_ready;

`ifdef ZERO_COUNT_ONES_SEL_EN
   // first_q marks that the next accepted word opens a new frame. On that word
   // the live sel_ones is used; later words use the value captured with it.
   logic first_q, sel_hold_q;

   assign sel_eff = first_q ? sel_ones : sel_hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_q    <= 1'b1;
         sel_hold_q <= 1'b0;
      end else if (xfer) begin
         if (first_q) begin
            sel_hold_q <= sel_ones;
         end
         first_q <= in_last;
      end
   end
`else
   assign sel_eff = 1'b0;
`endif

   // Bits to be counted: inverted data for zero counting, raw data for ones.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
      assign cnt_bits[gi] = sel_eff ? in_data[gi] : ~in_data[gi];
   end

   always_comb begin
      z = '0;
      for (int i = 0; i < WIDTH; i++) begin
         z = z + ZW'(cnt_bits[i]);
      end
   end

   // Next accumulator values. Parity and residue are tracked from z directly,
   // so they stay exact after the count saturates.
   always_comb begin
      sum     = SW'(acc_q) + SW'(z);
      sat     = (sum > CNT_MAX);
      acc_d   = sat ? CNT_W'(CNT_MAX) : CNT_W'(sum);
      ovf_d   = ovf_q | sat;
      par_d   = par_q ^ z[0];
      res_sum = (32'(res_q) + (32'(z) % MOD_U)) % MOD_U;
      res_d   = RW'(res_sum);
   end

   // Accumulators and the result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         par_q       <= 1'b0;
         res_q       <= '0;
         ovf_q       <= 1'b0;
         out_count_q <= '0;
         out_even_q  <= 1'b0;
         out_mod_q   <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else if (xfer) begin
         if (in_last) begin
            out_count_q <= acc_d;
            out_even_q  <= ~par_d;
            out_mod_q   <= (res_d == '0);
            out_ovf_q   <= ovf_d;
            acc_q       <= '0;
            par_q       <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
         end else begin
            acc_q <= acc_d;
            par_q <= par_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (xfer && in_last) state_d = HOLD;
         HOLD:    if (out_ready)       state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state_q == ACCUM);
      out_valid = (state_q == HOLD);
   end

   assign out_count = out_count_q;
   assign out_even  = out_even_q;
   assign out_mod   = out_mod_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_zero_count_stream.sv
// -----------------------------------------------------------------------------
// tb_zero_count_stream
//
// Purpose:
//    Self-checking bench for zero_count_stream. Two instances share the same
//    stimulus:
//       dut   default parameters (CNT_W=16)
//       dut4  CNT_W=4, so that saturation is reached by short frames
//    Expected results come from the frame's word list: the total zero count
//    is summed directly, then clamped and reduced.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_zero_count_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_last, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid, out_even, out_mod, out_ovf;
   logic [15:0] out_count;
   logic        in_ready4, out_valid4, out_even4, out_mod4, out_ovf4;
   logic [3:0]  out_count4;
`ifdef ZERO_COUNT_ONES_SEL_EN
   logic        sel_ones = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   int frame_no = 0;

   always #5 clk = ~clk;

   zero_count_stream #(.WIDTH(16), .MOD(3), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_even  (out_even),
      .out_mod   (out_mod),
      .out_ovf   (out_ovf)
`ifdef ZERO_COUNT_ONES_SEL_EN
      ,
      .sel_ones  (sel_ones)
`endif
   );

   zero_count_stream #(.WIDTH(16), .MOD(3), .CNT_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .out_count (out_count4),
      .out_even  (out_even4),
      .out_mod   (out_mod4),
      .out_ovf   (out_ovf4)
`ifdef ZERO_COUNT_ONES_SEL_EN
      ,
      .sel_ones  (sel_ones)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (frame %0d, t=%0t)", tag, got, exp, frame_no, $time);
      end
   endtask

   function automatic int unsigned true_zeros(input logic [15:0] w[$]);
      int unsigned t = 0;
      foreach (w[i]) t += 16 - $countones(w[i]);
      return t;
   endfunction

   // Sends one frame, checks the result, holds it for bp cycles, then accepts it.
   task automatic run_frame(input logic [15:0] words[$], input int max_gap, input int bp);
      int unsigned tot;
      int unsigned e16, e4;
      tot = true_zeros(words);
      e16 = (tot > 65535) ? 65535 : tot;
      e4  = (tot > 15) ? 15 : tot;
      frame_no++;
      foreach (words[i]) begin
         int gaps;
         gaps = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
         for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            in_last  = 1'($urandom);
         end
         @(negedge clk);
         check("in_ready_accum", in_ready, 1);
         check("in_ready4_accum", in_ready4, 1);
         check("out_valid_accum", out_valid, 0);
         in_valid = 1'b1;
         in_data  = words[i];
         in_last  = (i == words.size() - 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      $display("frame %0d words=%0d zeros=%0d count=%0d count4=%0d even=%0d mod=%0d ovf=%0d ovf4=%0d",
               frame_no, words.size(), tot, out_count, out_count4, out_even, out_mod, out_ovf, out_ovf4);
      check("out_valid", out_valid, 1);
      check("out_valid4", out_valid4, 1);
      check("in_ready_hold", in_ready, 0);
      check("count", out_count, e16);
      check("even", out_even, (tot % 2) == 0);
      check("mod", out_mod, (tot % 3) == 0);
      check("ovf", out_ovf, tot > 65535);
      check("count4", out_count4, e4);
      check("even4", out_even4, (tot % 2) == 0);
      check("mod4", out_mod4, (tot % 3) == 0);
      check("ovf4", out_ovf4, tot > 15);
      // Backpressure: inputs offered while holding must be ignored.
      for (int b = 0; b < bp; b++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = 16'($urandom);
         in_last   = 1'($urandom);
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_count", out_count, e16);
         check("bp_count4", out_count4, e4);
         check("bp_mod", out_mod, (tot % 3) == 0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("ack_out_valid", out_valid, 0);
      check("ack_in_ready", in_ready, 1);
      check("ack_count_kept", out_count, e16);
   endtask

   initial begin
      logic [15:0] q[$];
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = 16'h0;
      out_ready = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", out_count, 0);
      check("rst_even", out_even, 0);
      check("rst_mod", out_mod, 0);
      check("rst_ovf", out_ovf, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed frames
      q = {}; q.push_back(16'hFFFF);                              run_frame(q, 0, 0);
      q = {}; q.push_back(16'h0000);                              run_frame(q, 0, 0);
      q = {}; q.push_back(16'h00FF); q.push_back(16'hFFF0);       run_frame(q, 0, 5);
      q = {}; q.push_back(16'h0000); q.push_back(16'h0000);       run_frame(q, 0, 0);
      q = {}; q.push_back(16'hFFFF);                              run_frame(q, 0, 0);

      // Reset in mid-frame discards partial data
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0000;
      in_last  = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_count", out_count, 0);
      q = {}; q.push_back(16'hFFFE);                              run_frame(q, 0, 0);

      // Long frame pushing the 16-bit count exactly one past its maximum
      q = {};
      for (int i = 0; i < 4096; i++) q.push_back(16'h0000);
      run_frame(q, 0, 1);
      q = {}; q.push_back(16'hFFFF);                              run_frame(q, 0, 0);

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         int n;
         n = $urandom_range(6, 1);
         q = {};
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(3, 0))
               0:       q.push_back(16'h0000);
               1:       q.push_back(16'hFFFF);
               default: q.push_back(16'($urandom));
            endcase
         end
         run_frame(q, 2, $urandom_range(3, 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/zero_count_stream.md
Name: zero_count_stream

Overview:
Streaming successor to the combinational 16-bit zero counter. It accepts a frame of WIDTH-bit words over a valid/ready handshake and accumulates the number of 0 bits across the whole frame. At frame end it presents the total, an even-count flag and a divisible-by-MOD flag on a held output handshake. It sits between a word source and any consumer that needs frame-level zero statistics.

Parameters:
WIDTH, 16, input word width in bits (>=1)
MOD, 3, divisor for the divisibility flag (>=2)
CNT_W, 16, accumulated count width; count saturates at 2^CNT_W-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  input word
in_last  input  1  word is the last of its frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_count  output  CNT_W  zeros in frame (saturating)
out_even  output  1  1 if true zero count is even (0 counts as even)
out_mod  output  1  1 if true zero count mod MOD == 0 (0 counts as divisible)
out_ovf  output  1  1 if count saturated during the frame

Behaviour:
- Reset, asynchronous active-high: out_valid=0, out_count=0, out_even=0, out_mod=0, out_ovf=0. Accumulator=0, parity=0, residue=0, state ACCUM. A reset in mid-frame discards all partial frame data.
- States: ACCUM and HOLD. in_ready = (state==ACCUM). out_valid = (state==HOLD).
- Word transfer occurs when in_valid && in_ready. For each transferred word, z = number of 0 bits in in_data, where 0 <= z <= WIDTH.
  - acc_next = min(acc + z, 2^CNT_W-1); ovf_acc is set sticky when the sum exceeds the maximum.
  - parity_next = parity ^ z[0]. Parity stays exact even after saturation.
  - residue_next = (residue + (z mod MOD)) mod MOD. This is exact and independent of saturation. Residue is always kept in the range 0..MOD-1.
- ACCUM with transfer and in_last=0: update the accumulators and stay in ACCUM.
- ACCUM with transfer and in_last=1: on the same edge, load the outputs from the post-update values:
  - out_count = acc_next
  - out_even = !parity_next
  - out_mod = (residue_next==0)
  - out_ovf = ovf_next
  Then clear acc, parity, residue and ovf_acc, and go to HOLD. out_valid asserts in the cycle after the last-word handshake (latency 1).
- HOLD: outputs are stable while out_ready=0. in_ready=0, so input stalls.
- HOLD with out_ready=1: return to ACCUM. out_valid=0 and in_ready=1 from the next cycle. The output data registers keep their last values.
- Every frame is at least one word, because in_last travels with a word. A single-word frame is legal.
- in_data and in_last are ignored when no transfer occurs.

Optional Feature:
Macro ZERO_COUNT_ONES_SEL_EN.
- Defined: adds port sel_ones (input, 1). sel_ones is sampled on the first transfer of each frame and held for that frame.
  - When sel_ones=1, z counts 1 bits instead of 0 bits for every word of that frame.
  - All flag, saturation and handshake rules are unchanged.
- Not defined: the port is absent and z always counts 0 bits.

Test Plan:
- Defaults. Single word 16'hFFFF, last=1 -> next cycle out_valid=1, count=0, even=1, mod=1, ovf=0.
- Single word 16'h0000, last=1 -> count=16, even=1, mod=0 (16 mod 3 = 1).
- Two-word frame 16'h00FF then 16'hFFF0 (last) -> count=12, even=1, mod=1. in_ready=1 throughout ACCUM.
- Backpressure. After a result, hold out_ready=0 for 5 cycles -> out_valid stays 1, outputs stay stable, in_ready=0. Driving in_valid=1 in this window has no effect. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-frame. Transfer 16'h0000 (last=0), pulse rst asynchronously, then send 16'hFFFE (last) -> count=1, even=0, mod=0.
- CNT_W=4. Two words 16'h0000 (true count 32) -> count=15, ovf=1, even=1, mod=0 (32 mod 3 = 2). The next frame 16'hFFFF -> count=0, ovf=0.
